sub16_serial: RTL and testbench
===============================

Name: sub16_serial

Overview:
- Bit-serial 16-bit subtractor: computes a - b - borrow_in one bit per clock, using a single full-adder cell and a carry flip-flop.
- It is the inverse operation of the combinational 16-bit adder in the ALU library: same operand widths, with borrow in place of carry.
- It sits beside add16bits in the ALU area and trades 16 cycles of latency for roughly one full-adder of area.
- Start/busy/done handshake to the controlling datapath.

Parameters:
- WIDTH, 16, operand and result width in bits; the counter is sized to ceil(log2(WIDTH+1)).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request pulse; accepted only while busy=0.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- borrow_in  input  1  borrow into bit 0; sampled on the accepting edge only.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  result a - b - borrow_in, modulo 2^WIDTH.
- borrow_out  output  1  1 when a < b + borrow_in (unsigned).

Behaviour:
- Arithmetic: diff = a + ~b + ~borrow_in, done serially. The carry flop is initialised to ~borrow_in. borrow_out = ~(final carry).
- Reset (rst_n=0 at an edge):
  - state=IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, internal shift registers=0.
  - Overrides every other input, including mid-operation; the aborted result is discarded and done is never raised for it.
- FSM states: IDLE, RUN.
- IDLE:
  - If start=1 at edge E0: latch a, b and borrow_in into shift registers; set carry=~borrow_in and counter=0.
  - Go to RUN; busy=1 from E0.
- RUN, at edges E1..E16:
  - Process bit i=counter: sum_i = a_i ^ ~b_i ^ carry; carry = majority(a_i, ~b_i, carry).
  - Shift sum_i into the result register MSB-first, so the result is LSB-aligned after 16 shifts.
  - Increment counter.
- At edge E16 (counter reaches WIDTH-1 → done):
  - diff and borrow_out are updated; done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: start at E0 → done visible after E16 (16 cycles).
- Back-to-back: start=1 during the done cycle is accepted at E17; no bubble beyond the done cycle.
- start while busy=1 is ignored, with no queuing. The a/b/borrow_in inputs may change freely during RUN without affecting the result.
- diff and borrow_out hold their last value until the next completion or reset. They are not updated bit-by-bit; the internal result register is separate from diff.
- done is never high while busy is high.
- Wrap-around:
  - 0x0000 - 0x0001 = 0xFFFF with borrow_out=1.
  - Results are always taken modulo 2^WIDTH.

Optional Feature:
- Macro: SUB16_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port overflow (1 bit), reset 0.
  - Updated with diff at completion.
  - overflow = 1 when the two's-complement result is out of range: (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]).
  - Held until the next completion.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a=0x0000, b=0x0000, borrow_in=0, start pulse → done exactly 16 cycles after the accepting edge; diff=0x0000, borrow_out=0; busy high for 16 cycles.
- a=0x0000, b=0x0001, borrow_in=0 → diff=0xFFFF, borrow_out=1. Then a=0x1234, b=0x0234 → diff=0x1000, borrow_out=0.
- a=0xFFFF, b=0xFFFF, borrow_in=1 → diff=0xFFFF, borrow_out=1. In the same run, pulse start again mid-RUN with a=0x0005, b=0x0001 → ignored; the result is unchanged and only one done pulse occurs.
- Back-to-back: start held high through the done cycle with a=0x0010, b=0x0003 → second run accepted on the next edge; second done after 16 more cycles; diff=0x000D.
- Start a=0x00FF, b=0x0001; assert rst_n=0 on cycle 7 for one edge → busy=0, done=0, diff=0; no done pulse follows. A fresh start then works normally.
- With SUB16_OVERFLOW_FLAG_EN: a=0x8000, b=0x0001 → diff=0x7FFF, overflow=1, borrow_out=0. Then a=0x0005, b=0x0003 → diff=0x0002, overflow=0.

Source files
------------

// File: rtl/sub16_serial.sv
// Bit-serial subtractor: a - b - borrow_in, one bit per clock via a single full-adder and carry flop.
// Optional overflow output enabled by defining SUB16_OVERFLOW_FLAG_EN.
module sub16_serial #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SUB16_OVERFLOW_FLAG_EN
   ,
   output logic             overflow
`endif
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] res;
   logic             carry;
   logic             nb, sum_bit, carry_nxt, last;

   // Subtraction as a + ~b + ~borrow_in; carry holds the inverted borrow.
   assign nb        = ~b_sh[0];
   assign sum_bit   = a_sh[0] ^ nb ^ carry;
   assign carry_nxt = (a_sh[0] & nb) | (a_sh[0] & carry) | (nb & carry);
   assign last      = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         a_sh       <= '0;
         b_sh       <= '0;
         res        <= '0;
         carry      <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
`ifdef SUB16_OVERFLOW_FLAG_EN
         overflow   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= ~borrow_in;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= carry_nxt;
               res   <= {sum_bit, res[WIDTH-2:1]};
               cnt   <= cnt + CW'(1);
               if (last) begin
                  // Final bit goes straight into diff; res holds the lower WIDTH-1 bits.
                  diff       <= {sum_bit, res};
                  borrow_out <= ~carry_nxt;
                  done       <= 1'b1;
`ifdef SUB16_OVERFLOW_FLAG_EN
                  // Operand MSBs are sitting at bit 0 of the shift registers now.
                  overflow   <= (a_sh[0] != b_sh[0]) && (sum_bit != a_sh[0]);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sub16_serial.sv
// Self-checking bench for sub16_serial: vector table, scoreboard queue, and multi-cycle corner sequences.
module tb_sub16_serial;

   logic        clk = 1'b0;
   logic        rst_n, start, borrow_in;
   logic [15:0] a, b;
   logic        busy, done, borrow_out;
   logic [15:0] diff;
`ifdef SUB16_OVERFLOW_FLAG_EN
   logic        overflow;
`endif

   sub16_serial #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SUB16_OVERFLOW_FLAG_EN
      ,
      .overflow   (overflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] d;
      logic        bo;
      logic        ov;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      logic        bo;
      logic        ov;
   } exp_t;

   vec_t vecs[11];
   exp_t sb[$];
   int   tests    = 0;
   int   failed   = 0;
   int   done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to the next falling edge and retire any completed result against the scoreboard.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (done === 1'b1) begin
         done_cnt++;
         chk("done_busy_exclusive", {31'd0, busy}, 32'd0);
         if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
         end else begin
            e = sb.pop_front();
            chk("diff", {16'd0, diff}, {16'd0, e.d});
            chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.bo});
`ifdef SUB16_OVERFLOW_FLAG_EN
            chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
`endif
         end
      end
   endtask

   task automatic drive_start(input logic [15:0] av, input logic [15:0] bv, input logic bi);
      a         = av;
      b         = bv;
      borrow_in = bi;
      start     = 1'b1;
   endtask

   // Wait for done from the cycle after acceptance; returns cycles waited, bounded.
   task automatic wait_done(output int cycles, output bit busy_ok);
      cycles  = 0;
      busy_ok = 1'b1;
      while (cycles < 40) begin
         tick();
         cycles++;
         if (done === 1'b1) break;
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   task automatic run_one(input vec_t v);
      int cycles;
      bit busy_ok;
      drive_start(v.a, v.b, v.bin);
      sb.push_back('{d: v.d, bo: v.bo, ov: v.ov});
      tick();
      start = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_done(cycles, busy_ok);
      chk("latency", cycles, 32'd16);
      chk("busy_held", {31'd0, busy_ok}, 32'd1);
      chk("busy_low_at_done", {31'd0, busy}, 32'd0);
      tick();
      chk("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int cycles;
      int d0;
      bit busy_ok;

      vecs[0]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[2]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[4]  = '{16'h0010, 16'h0003, 1'b0, 16'h000D, 1'b0, 1'b0};
      vecs[5]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
      vecs[6]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
      vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[8]  = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
      vecs[9]  = '{16'h0001, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0};
      vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};

      rst_n     = 1'b0;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      borrow_in = 1'b0;
      tick();
      tick();
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_diff", {16'd0, diff}, 32'd0);
      chk("reset_borrow", {31'd0, borrow_out}, 32'd0);
`ifdef SUB16_OVERFLOW_FLAG_EN
      chk("reset_overflow", {31'd0, overflow}, 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) run_one(vecs[i]);

      // Second start mid-run must be ignored; exactly one done follows.
      drive_start(16'hFFFF, 16'hFFFF, 1'b1);
      sb.push_back('{d: 16'hFFFF, bo: 1'b1, ov: 1'b0});
      tick();
      start = 1'b0;
      d0 = done_cnt;
      repeat (4) tick();
      drive_start(16'h0005, 16'h0001, 1'b0);
      tick();
      start = 1'b0;
      repeat (30) tick();
      chk("midrun_single_done", done_cnt - d0, 32'd1);
      chk("midrun_diff_held", {16'd0, diff}, 32'h0000_FFFF);

      // Back-to-back: start held high; inputs changed during RUN, accepted again at done.
      drive_start(16'h1234, 16'h0234, 1'b0);
      sb.push_back('{d: 16'h1000, bo: 1'b0, ov: 1'b0});
      tick();
      drive_start(16'h0010, 16'h0003, 1'b0);
      wait_done(cycles, busy_ok);
      chk("b2b_first_latency", cycles, 32'd16);
      sb.push_back('{d: 16'h000D, bo: 1'b0, ov: 1'b0});
      tick();
      start = 1'b0;
      chk("b2b_second_accepted", {31'd0, busy}, 32'd1);
      chk("b2b_no_done", {31'd0, done}, 32'd0);
      wait_done(cycles, busy_ok);
      chk("b2b_second_latency", cycles, 32'd16);
      tick();

      // Reset mid-run discards the operation.
      drive_start(16'h00FF, 16'h0001, 1'b0);
      tick();
      start = 1'b0;
      d0 = done_cnt;
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_diff", {16'd0, diff}, 32'd0);
      chk("abort_borrow", {31'd0, borrow_out}, 32'd0);
      repeat (25) tick();
      chk("abort_no_done", done_cnt - d0, 32'd0);
      run_one('{16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0});

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
